// File: rtl/e1_tx_bd_sched_pkg.sv
// rtl/e1_tx_bd_sched_pkg.sv - shared state encodings and defaults for the E1 TX BD scheduler
package e1_tx_bd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } sched_state_t;

    localparam int MFW_DEF   = 7;
    localparam int QLOG2_DEF = 2;

endpackage

// File: rtl/e1_bd_fifo.sv
// rtl/e1_bd_fifo.sv - synchronous descriptor FIFO, MSB-compare full/empty
module e1_bd_fifo #(
    parameter int W     = 9,
    parameter int QLOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int DEPTH = 1 << QLOG2;
    localparam logic [QLOG2:0] PTR_ONE = {{QLOG2{1'b0}}, 1'b1};

    logic [W-1:0]   mem [DEPTH];
    logic [QLOG2:0] wp;
    logic [QLOG2:0] rp;

    assign empty = (wp == rp);
    assign full  = (wp[QLOG2] != rp[QLOG2]) && (wp[QLOG2-1:0] == rp[QLOG2-1:0]);
    assign head  = mem[rp[QLOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
        end
    end

    // A push on a full queue is only issued with a same-cycle pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp[QLOG2-1:0]] <= din;
        end
    end

endmodule

// File: rtl/e1_tx_bd_sched.sv
// rtl/e1_tx_bd_sched.sv - E1 TX buffer-descriptor scheduler: submit/completion queues, boundary start/stop
module e1_tx_bd_sched
    import e1_tx_bd_sched_pkg::*;
#(
    parameter int MFW   = MFW_DEF,
    parameter int QLOG2 = QLOG2_DEF,
    parameter int MCW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MFW-1:0] sub_mf,
    input  logic [1:0]     sub_crc_e,
    input  logic           sub_valid,
    output logic           sub_ready,
    output logic [MFW-1:0] cpl_mf,
    output logic           cpl_valid,
    input  logic           cpl_ack,
    output logic [MFW-1:0] bd_mf,
    output logic [1:0]     bd_crc_e,
    output logic           bd_valid,
    input  logic           bd_mf_start,
    input  logic           bd_done,
    input  logic           bd_miss,
    input  logic           ctrl_run,
    input  logic           ctrl_flush,
    output logic [1:0]     stat_state,
    output logic           stat_active,
    output logic           stat_underrun,
    output logic           stat_cpl_ovf,
    input  logic           stat_clr,
    output logic [MCW-1:0] stat_miss_cnt
);

    sched_state_t   state, state_nxt;
    logic           active;
    logic           sub_full, sub_empty, cpl_full, cpl_empty;
    logic [MFW+1:0] sub_head;
    logic [MFW-1:0] cpl_head;
    logic           do_flush, done_ok, sub_push, cpl_pop, cpl_push, miss_run;

    assign do_flush = ctrl_flush && (state == ST_IDLE) && !active;
    assign done_ok  = bd_done && active;
    assign sub_push = sub_valid && !sub_full && !do_flush;
    assign cpl_pop  = cpl_ack && !cpl_empty;
    assign cpl_push = done_ok && (!cpl_full || cpl_pop);
    assign miss_run = bd_miss && (state == ST_RUN);

    e1_bd_fifo #(.W(MFW + 2), .QLOG2(QLOG2)) u_sub_q (
        .clk   (clk),
        .rst   (rst),
        .push  (sub_push),
        .din   ({sub_mf, sub_crc_e}),
        .pop   (done_ok),
        .flush (do_flush),
        .full  (sub_full),
        .empty (sub_empty),
        .head  (sub_head)
    );

    e1_bd_fifo #(.W(MFW), .QLOG2(QLOG2)) u_cpl_q (
        .clk   (clk),
        .rst   (rst),
        .push  (cpl_push),
        .din   (sub_head[MFW+1:2]),
        .pop   (cpl_pop),
        .flush (1'b0),
        .full  (cpl_full),
        .empty (cpl_empty),
        .head  (cpl_head)
    );

    assign sub_ready   = !sub_full;
    assign cpl_valid   = !cpl_empty;
    assign cpl_mf      = cpl_empty ? '0 : cpl_head;
    assign bd_mf       = sub_empty ? '0 : sub_head[MFW+1:2];
    assign bd_crc_e    = sub_empty ? '0 : sub_head[1:0];
    assign bd_valid    = ((state == ST_RUN) && !sub_empty) || active;
    assign stat_state  = state;
    assign stat_active = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // STOP retires to IDLE on the same edge that finishes the latched multiframe.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_run) state_nxt = ST_RUN;
            ST_RUN:  if (!ctrl_run) state_nxt = ST_STOP;
            ST_STOP: begin
                if (ctrl_run) begin
                    state_nxt = ST_RUN;
                end else if (!active || done_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
        end else if (done_ok) begin
            active <= 1'b0;
        end else if (bd_mf_start && bd_valid) begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_underrun <= 1'b0;
            stat_cpl_ovf  <= 1'b0;
            stat_miss_cnt <= '0;
        end else begin
            if (miss_run) begin
                stat_underrun <= 1'b1;
                if (stat_miss_cnt != '1) begin
                    stat_miss_cnt <= stat_miss_cnt + MCW'(1);
                end
            end
            if (done_ok && cpl_full && !cpl_ack) begin
                stat_cpl_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e1_tx_bd_sched.sv
// tb/tb_e1_tx_bd_sched.sv - self-checking bench for e1_tx_bd_sched with queue-level reference model
module tb_e1_tx_bd_sched;

    localparam int MFW = 7;
    localparam int MCW = 16;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [MFW-1:0] sub_mf = '0;
    logic [1:0]     sub_crc_e = '0;
    logic           sub_valid = 1'b0;
    logic           sub_ready;
    logic [MFW-1:0] cpl_mf;
    logic           cpl_valid;
    logic           cpl_ack = 1'b0;
    logic [MFW-1:0] bd_mf;
    logic [1:0]     bd_crc_e;
    logic           bd_valid;
    logic           bd_mf_start = 1'b0;
    logic           bd_done = 1'b0;
    logic           bd_miss = 1'b0;
    logic           ctrl_run = 1'b0;
    logic           ctrl_flush = 1'b0;
    logic [1:0]     stat_state;
    logic           stat_active;
    logic           stat_underrun;
    logic           stat_cpl_ovf;
    logic           stat_clr = 1'b0;
    logic [MCW-1:0] stat_miss_cnt;

    int n_pass = 0;
    int n_total = 0;

    e1_tx_bd_sched #(.MFW(MFW), .QLOG2(2), .MCW(MCW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sub_mf        (sub_mf),
        .sub_crc_e     (sub_crc_e),
        .sub_valid     (sub_valid),
        .sub_ready     (sub_ready),
        .cpl_mf        (cpl_mf),
        .cpl_valid     (cpl_valid),
        .cpl_ack       (cpl_ack),
        .bd_mf         (bd_mf),
        .bd_crc_e      (bd_crc_e),
        .bd_valid      (bd_valid),
        .bd_mf_start   (bd_mf_start),
        .bd_done       (bd_done),
        .bd_miss       (bd_miss),
        .ctrl_run      (ctrl_run),
        .ctrl_flush    (ctrl_flush),
        .stat_state    (stat_state),
        .stat_active   (stat_active),
        .stat_underrun (stat_underrun),
        .stat_cpl_ovf  (stat_cpl_ovf),
        .stat_clr      (stat_clr),
        .stat_miss_cnt (stat_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: descriptors as {mf, crc_e} integers in plain queues.
    int q_sub[$];
    int q_cpl[$];
    int m_state;     // 0 idle, 1 run, 2 stop
    bit m_active;
    bit m_unr;
    bit m_ovf;
    int m_cnt;

    function automatic bit m_bd_valid();
        return (m_state == 1 && q_sub.size() > 0) || m_active;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_sub.delete();
            q_cpl.delete();
            m_state = 0;
            m_active = 0;
            m_unr = 0;
            m_ovf = 0;
            m_cnt = 0;
        end else begin
            bit vld, done, flush, sub_full, cpl_full, act_was;
            int head;
            vld = m_bd_valid();
            act_was = m_active;
            done = bd_done && m_active;
            flush = ctrl_flush && m_state == 0 && !m_active;
            sub_full = (q_sub.size() == DEPTH);
            cpl_full = (q_cpl.size() == DEPTH);
            if (cpl_ack && q_cpl.size() > 0) void'(q_cpl.pop_front());
            if (done) begin
                head = q_sub.pop_front();
                if (!cpl_full || cpl_ack) q_cpl.push_back(head / 4);
                else m_ovf = 1;
            end
            if (flush) q_sub.delete();
            else if (sub_valid && !sub_full) q_sub.push_back(int'(sub_mf) * 4 + int'(sub_crc_e));
            if (done) m_active = 0;
            else if (bd_mf_start && vld) m_active = 1;
            if (bd_miss && m_state == 1) begin
                m_unr = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (stat_clr) begin
                m_unr = 0;
                m_ovf = 0;
                m_cnt = 0;
            end
            case (m_state)
                0: if (ctrl_run) m_state = 1;
                1: if (!ctrl_run) m_state = 2;
                default: if (ctrl_run) m_state = 1;
                         else if (!act_was || done) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_sub_ready", int'(sub_ready), int'(q_sub.size() < DEPTH));
            chk("m_bd_valid", int'(bd_valid), int'(m_bd_valid()));
            chk("m_bd_mf", int'(bd_mf), q_sub.size() > 0 ? q_sub[0] / 4 : 0);
            chk("m_bd_crc_e", int'(bd_crc_e), q_sub.size() > 0 ? q_sub[0] % 4 : 0);
            chk("m_cpl_valid", int'(cpl_valid), int'(q_cpl.size() > 0));
            chk("m_cpl_mf", int'(cpl_mf), q_cpl.size() > 0 ? q_cpl[0] : 0);
            chk("m_state", int'(stat_state), m_state);
            chk("m_active", int'(stat_active), int'(m_active));
            chk("m_underrun", int'(stat_underrun), int'(m_unr));
            chk("m_cpl_ovf", int'(stat_cpl_ovf), int'(m_ovf));
            chk("m_miss_cnt", int'(stat_miss_cnt), m_cnt);
        end
    end

    task automatic submit(input int mf, input int crc);
        sub_mf = MFW'(mf);
        sub_crc_e = 2'(crc);
        sub_valid = 1'b1;
        @(negedge clk);
        sub_valid = 1'b0;
    endtask

    task automatic mf_cycle();
        bd_mf_start = 1'b1;
        @(negedge clk);
        bd_mf_start = 1'b0;
        bd_done = 1'b1;
        @(negedge clk);
        bd_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_bd_valid", int'(bd_valid), 0);
        chk("rst_sub_ready", int'(sub_ready), 1);
        chk("rst_state", int'(stat_state), 0);

        // Underrun counting on an empty queue in RUN
        ctrl_run = 1'b1;
        @(negedge clk);
        bd_mf_start = 1'b1;
        bd_miss = 1'b1;
        @(negedge clk);
        bd_mf_start = 1'b0;
        @(negedge clk);
        bd_miss = 1'b0;
        chk("miss_bd_valid", int'(bd_valid), 0);
        chk("miss_underrun", int'(stat_underrun), 1);
        chk("miss_cnt", int'(stat_miss_cnt), 2);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("clr_cnt", int'(stat_miss_cnt), 0);
        chk("clr_underrun", int'(stat_underrun), 0);

        // Basic descriptor flow
        submit(5, 2);
        submit(6, 1);
        chk("head_mf", int'(bd_mf), 5);
        chk("head_crc", int'(bd_crc_e), 2);
        chk("head_valid", int'(bd_valid), 1);
        mf_cycle();
        chk("next_mf", int'(bd_mf), 6);
        chk("cpl_valid", int'(cpl_valid), 1);
        chk("cpl_mf", int'(cpl_mf), 5);
        cpl_ack = 1'b1;
        @(negedge clk);
        cpl_ack = 1'b0;
        chk("cpl_popped", int'(cpl_valid), 0);

        // Full submit queue and dropped 5th push
        submit(7, 0);
        submit(8, 3);
        submit(9, 1);
        chk("full_ready", int'(sub_ready), 0);
        submit(10, 2);
        chk("full_head", int'(bd_mf), 6);
        mf_cycle();
        chk("full_freed", int'(sub_ready), 1);

        // Stop on a multiframe boundary
        bd_mf_start = 1'b1;
        @(negedge clk);
        bd_mf_start = 1'b0;
        chk("stop_active", int'(stat_active), 1);
        ctrl_run = 1'b0;
        @(negedge clk);
        chk("stop_state", int'(stat_state), 2);
        chk("stop_valid", int'(bd_valid), 1);
        chk("stop_head", int'(bd_mf), 7);
        bd_done = 1'b1;
        @(negedge clk);
        bd_done = 1'b0;
        chk("stop_idle", int'(stat_state), 0);
        chk("stop_valid0", int'(bd_valid), 0);
        chk("stop_retained", int'(bd_mf), 8);

        // Completion overflow, then same-cycle ack on a full queue
        submit(11, 0);
        submit(12, 1);
        ctrl_run = 1'b1;
        @(negedge clk);
        mf_cycle();
        mf_cycle();
        mf_cycle();
        chk("ovf_set", int'(stat_cpl_ovf), 1);
        chk("ovf_head", int'(cpl_mf), 6);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        submit(13, 2);
        bd_mf_start = 1'b1;
        @(negedge clk);
        bd_mf_start = 1'b0;
        bd_done = 1'b1;
        cpl_ack = 1'b1;
        @(negedge clk);
        bd_done = 1'b0;
        cpl_ack = 1'b0;
        chk("ack_no_ovf", int'(stat_cpl_ovf), 0);
        chk("ack_head", int'(cpl_mf), 7);

        // Flush in IDLE wins over a push; flush in RUN is ignored
        ctrl_run = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_idle", int'(stat_state), 0);
        submit(14, 0);
        submit(15, 3);
        ctrl_flush = 1'b1;
        bd_miss = 1'b1;
        sub_mf = 7'd16;
        sub_valid = 1'b1;
        @(negedge clk);
        ctrl_flush = 1'b0;
        bd_miss = 1'b0;
        sub_valid = 1'b0;
        chk("flush_ready", int'(sub_ready), 1);
        chk("flush_mf", int'(bd_mf), 0);
        chk("idle_miss", int'(stat_miss_cnt), 0);
        ctrl_run = 1'b1;
        @(negedge clk);
        chk("flush_run_valid", int'(bd_valid), 0);
        submit(20, 1);
        submit(21, 2);
        ctrl_flush = 1'b1;
        @(negedge clk);
        ctrl_flush = 1'b0;
        chk("run_flush_head", int'(bd_mf), 20);
        chk("run_flush_valid", int'(bd_valid), 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/e1_tx_bd_sched.md
Name: e1_tx_bd_sched

Overview:
- Buffer-descriptor scheduler for the E1 transmit path.
- Software submits multiframe descriptors (buffer MF index + CRC-E bits) into a submit queue.
- The block presents the queue head to the TX framer BD interface (bd_mf / bd_crc_e / bd_valid) and holds it stable for the whole multiframe.
- It retires the head on bd_done into a completion queue, counts underruns (bd_miss), and sequences clean start/stop only on multiframe boundaries.

Parameters:
- MFW, 7, width of buffer multiframe index.
- QLOG2, 2, log2 depth of submit and completion queues (depth 4).
- MCW, 16, width of underrun counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sub_mf  in  MFW  descriptor MF index to submit.
- sub_crc_e  in  2  descriptor CRC-E bits.
- sub_valid  in  1  submit request.
- sub_ready  out  1  submit queue not full.
- cpl_mf  out  MFW  completed descriptor MF index (completion queue head).
- cpl_valid  out  1  completion queue not empty.
- cpl_ack  in  1  pop completion head.
- bd_mf  out  MFW  to TX: current descriptor MF.
- bd_crc_e  out  2  to TX: current descriptor CRC-E.
- bd_valid  out  1  to TX: descriptor present.
- bd_mf_start  in  1  from TX: pulse in the cycle the framer samples bd_valid at multiframe start.
- bd_done  in  1  from TX: multiframe finished.
- bd_miss  in  1  from TX: multiframe started without descriptor.
- ctrl_run  in  1  level: 1 = schedule, 0 = stop at next boundary.
- ctrl_flush  in  1  pulse: empty submit queue; honoured in IDLE only.
- stat_state  out  2  00 IDLE, 01 RUN, 10 STOP.
- stat_active  out  1  a descriptor is latched by TX.
- stat_underrun  out  1  sticky underrun flag.
- stat_cpl_ovf  out  1  sticky completion-overflow flag.
- stat_clr  in  1  pulse: clear both sticky flags and the miss counter.
- stat_miss_cnt  out  MCW  saturating underrun count.

Behaviour:
- Reset values:
  - State IDLE; both queues empty; active = 0.
  - sub_ready = 1; cpl_valid = 0; bd_valid = 0; bd_mf / bd_crc_e = 0.
  - Sticky flags = 0; counter = 0.
- Submit queue:
  - Push when sub_valid & sub_ready; sub_ready = !full of the current cycle.
  - A same-cycle pop does not free a slot for a same-cycle push.
- Head output:
  - bd_mf / bd_crc_e = submit queue head, or 0 when empty.
  - Head never changes while active = 1.
- active:
  - Set on bd_mf_start & bd_valid.
  - Cleared on bd_done.
  - bd_done while active = 0 is ignored.
- bd_valid = (state == RUN & !empty) | active. It is combinational from registers, so a change is visible to TX the same cycle.
- On bd_done with active = 1:
  - Pop the submit head.
  - Push {head mf} to the completion queue in the same cycle.
  - If the completion queue is full and cpl_ack is not asserted that cycle: drop the entry and set stat_cpl_ovf.
  - Same-cycle cpl_ack plus push on a full queue succeeds.
- Completion queue: pop on cpl_ack & cpl_valid; cpl_ack while empty is ignored.
- Underrun handling, on bd_miss in RUN:
  - Set stat_underrun.
  - stat_miss_cnt += 1, saturating at all-ones.
  - bd_miss in IDLE or STOP is not counted.
- stat_clr:
  - Takes priority over a same-cycle set or increment.
  - The counter goes to 0 and the flags to 0.
- State machine:
  - IDLE -> RUN when ctrl_run = 1.
  - RUN -> STOP when ctrl_run = 0.
  - STOP -> RUN when ctrl_run = 1.
  - STOP -> IDLE when active = 0. If nothing is latched this happens the next cycle; otherwise it waits for bd_done.
  - In STOP, new bd_mf_start does not set active because bd_valid = active = 0. The queue head is kept.
- ctrl_flush:
  - In IDLE with active = 0: both queue pointers of the submit queue reset to empty within one cycle; flushed entries are not reported.
  - In any other state it is ignored.
  - Flush and push in the same cycle: flush wins and the push is dropped.
- Pointer widths are QLOG2+1 bits, with full/empty decided by MSB compare. Wrap-around is natural modulo 2^(QLOG2+1).

Decomposition:
- Shared package/header:
  - State encodings (ST_IDLE = 0, ST_RUN = 1, ST_STOP = 2).
  - Default MFW and QLOG2.
- One natural sub-module: e1_bd_fifo.
  - Synchronous FIFO, parameterised width and depth.
  - Ports: push, pop, flush, full, empty, head data.
  - Instantiated twice: submit queue with width MFW+2, completion queue with width MFW.

Test Plan:
- Reset then ctrl_run = 1 with an empty queue; pulse bd_mf_start, bd_miss twice -> bd_valid = 0, stat_underrun = 1, stat_miss_cnt = 2; stat_clr -> both 0.
- Submit mf = 5 crc_e = 2 and mf = 6 crc_e = 1 in RUN -> bd_mf = 5, bd_crc_e = 2, bd_valid = 1. Then bd_mf_start, bd_done -> bd_mf = 6, cpl_valid = 1, cpl_mf = 5; cpl_ack -> cpl_valid = 0.
- Submit 4 entries -> sub_ready = 0 after the 4th. A 5th sub_valid is dropped. Pop via bd_mf_start plus bd_done -> sub_ready = 1 the next cycle.
- In RUN with active = 1, drop ctrl_run -> stat_state = STOP and bd_valid stays 1 with the head unchanged. On bd_done -> IDLE and bd_valid = 0; the remaining entries are retained.
- Fill the completion queue (4 entries, no cpl_ack), then a 5th bd_done -> stat_cpl_ovf = 1 and cpl_mf still equals the first entry. Repeat with cpl_ack in the same cycle -> no overflow.
- In IDLE with 3 queued entries, pulse ctrl_flush together with sub_valid -> queue empty, sub_ready = 1, and a later ctrl_run gives bd_valid = 0. ctrl_flush in RUN -> queue unchanged.
